// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit counter states and BTB entry status.
package bp_pkg;

    typedef enum logic [1:0] {
        ST_STRONG_NT = 2'b00,
        ST_WEAK_NT   = 2'b01,
        ST_WEAK_T    = 2'b10,
        ST_STRONG_T  = 2'b11
    } ctr_state_t;

    // Per-entry status kept in flops so reset and flush complete in one edge.
    typedef struct packed {
        logic       valid;
        ctr_state_t ctr;
    } btb_entry_t;

    localparam ctr_state_t CTR_RESET = ST_WEAK_NT;
    localparam ctr_state_t CTR_ALLOC = ST_WEAK_T;

    function automatic logic predicts_taken(input ctr_state_t state);
        return state[1];
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_state_t state,
    input  logic       taken,
    output ctr_state_t next_state
);

    // Step one state toward the observed outcome, holding at both ends.
    always_comb begin
        next_state = state;
        case (state)
            ST_STRONG_NT: next_state = taken ? ST_WEAK_NT  : ST_STRONG_NT;
            ST_WEAK_NT:   next_state = taken ? ST_WEAK_T   : ST_STRONG_NT;
            ST_WEAK_T:    next_state = taken ? ST_STRONG_T : ST_WEAK_NT;
            ST_STRONG_T:  next_state = taken ? ST_STRONG_T : ST_WEAK_T;
            default:      next_state = CTR_RESET;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational fetch lookup, EX-stage update.
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            predict_hit,
    output logic            predict_taken,
    output logic [XLEN-1:0] predict_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            flush_all
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    btb_entry_t      entry_r  [ENTRIES];
    logic [TAGW-1:0] tag_r    [ENTRIES];
    logic [XLEN-1:0] target_r [ENTRIES];

    logic [IDXW-1:0] rd_idx_s;
    logic [TAGW-1:0] rd_tag_s;
    logic            rd_hit_s;
    logic [IDXW-1:0] upd_idx_s;
    logic [TAGW-1:0] upd_tag_s;
    logic            upd_hit_s;
    ctr_state_t      ctr_next_s;
    logic            data_we_s;
    logic            unused_pc_bits_s;

    assign rd_idx_s  = if_pc[IDXW+1:2];
    assign rd_tag_s  = if_pc[XLEN-1:IDXW+2];
    assign upd_idx_s = upd_pc[IDXW+1:2];
    assign upd_tag_s = upd_pc[XLEN-1:IDXW+2];

    // Instruction-alignment bits never participate in index or tag.
    assign unused_pc_bits_s = ^{if_pc[1:0], upd_pc[1:0]};

    assign rd_hit_s  = entry_r[rd_idx_s].valid && (tag_r[rd_idx_s] == rd_tag_s);
    assign upd_hit_s = entry_r[upd_idx_s].valid && (tag_r[upd_idx_s] == upd_tag_s);

    // Tag/target are written on any taken update: on a hit the tag is unchanged,
    // on a miss it is the allocation. Reset and flush both suppress the update.
    assign data_we_s = upd_valid && upd_taken && !flush_all && !reset;

    sat_counter2 u_sat_counter2 (
        .state      (entry_r[upd_idx_s].ctr),
        .taken      (upd_taken),
        .next_state (ctr_next_s)
    );

    // Valid bits and counters: reset beats flush beats update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_r[i] <= '{valid: 1'b0, ctr: CTR_RESET};
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_r[i].valid <= 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_hit_s) begin
                entry_r[upd_idx_s].ctr <= ctr_next_s;
            end else if (upd_taken) begin
                entry_r[upd_idx_s] <= '{valid: 1'b1, ctr: CTR_ALLOC};
            end else begin
                entry_r[upd_idx_s] <= entry_r[upd_idx_s];
            end
        end else begin
            entry_r <= entry_r;
        end
    end

    // Tag and target storage; contents are qualified by the valid bit, so no reset.
    always_ff @(posedge clk) begin
        if (data_we_s) begin
            tag_r[upd_idx_s]    <= upd_tag_s;
            target_r[upd_idx_s] <= upd_target;
        end else begin
            tag_r    <= tag_r;
            target_r <= target_r;
        end
    end

    // Zero-latency prediction from the pre-update array contents.
    always_comb begin
        predict_hit    = 1'b0;
        predict_taken  = 1'b0;
        predict_target = '0;
        if (rd_hit_s) begin
            predict_hit    = 1'b1;
            predict_taken  = predicts_taken(entry_r[rd_idx_s].ctr);
            predict_target = target_r[rd_idx_s];
        end else begin
            predict_hit    = 1'b0;
            predict_taken  = 1'b0;
            predict_target = '0;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed, table-driven bench for branch_target_buffer (ENTRIES=16, XLEN=32).
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        predict_hit;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush_all;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    branch_target_buffer #(.ENTRIES(16), .XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .predict_hit    (predict_hit),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .flush_all      (flush_all)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [31:0] ipc;
        logic        eh;
        logic        et;
        logic [31:0] etgt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic flush, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic [31:0] ipc, input logic eh, input logic et,
                       input logic [31:0] etgt);
        vec_t v;
        v.rst = rst; v.flush = flush; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.ipc = ipc; v.eh = eh; v.et = et; v.etgt = etgt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic eh, input logic et,
                         input logic [31:0] etgt);
        tests_run++;
        if (predict_hit !== eh || predict_taken !== et || predict_target !== etgt) begin
            tests_failed++;
            $display("FAIL %s: got hit=%b taken=%b target=%h, expected hit=%b taken=%b target=%h",
                     name, predict_hit, predict_taken, predict_target, eh, et, etgt);
        end
    endtask

    task automatic drive(input logic rst, input logic flush, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                         input logic [31:0] ipc);
        reset = rst; flush_all = flush; upd_valid = uv; upd_pc = upc;
        upd_taken = ut; upd_target = utgt; if_pc = ipc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Look up pc with no update, check, then advance a cycle.
    task automatic look(input string name, input logic [31:0] pc, input logic eh,
                        input logic et, input logic [31:0] etgt);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, pc);
        #3;
        check(name, eh, et, etgt);
        tick();
    endtask

    task automatic upd(input logic rst, input logic flush, input logic [31:0] pc,
                       input logic [31:0] tgt);
        drive(rst, flush, 1'b1, pc, 1'b1, tgt, 32'h0);
        tick();
    endtask

    // Fill four entries plus check they hit, then kill them with flush or reset.
    task automatic populate_and_kill(input string tag, input logic use_reset);
        upd(1'b0, 1'b0, 32'h104, 32'h1104);
        upd(1'b0, 1'b0, 32'h108, 32'h1108);
        upd(1'b0, 1'b0, 32'h10C, 32'h110C);
        upd(1'b0, 1'b0, 32'h110, 32'h1110);
        look({tag, "_pre_104"}, 32'h104, 1'b1, 1'b1, 32'h1104);
        look({tag, "_pre_106_lowbits"}, 32'h106, 1'b1, 1'b1, 32'h1104);
        look({tag, "_pre_110"}, 32'h110, 1'b1, 1'b1, 32'h1110);
        upd(use_reset, !use_reset, 32'h1C0, 32'h5000);
        look({tag, "_post_104"}, 32'h104, 1'b0, 1'b0, 32'h0);
        look({tag, "_post_108"}, 32'h108, 1'b0, 1'b0, 32'h0);
        look({tag, "_post_10C"}, 32'h10C, 1'b0, 1'b0, 32'h0);
        look({tag, "_post_110"}, 32'h110, 1'b0, 1'b0, 32'h0);
        look({tag, "_post_1C0"}, 32'h1C0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        // rst flush uv upc ut utgt | ipc hit taken target (lookup before the edge)
        add(1, 0, 0, 32'h000, 0, 32'h000, 32'h100, 0, 0, 32'h000);
        add(1, 0, 1, 32'h100, 1, 32'h200, 32'h100, 0, 0, 32'h000); // discarded
        add(0, 0, 1, 32'h100, 1, 32'h200, 32'h100, 0, 0, 32'h000); // alloc -> 10
        add(0, 0, 1, 32'h100, 0, 32'h000, 32'h100, 1, 1, 32'h200); // -> 01
        add(0, 0, 1, 32'h100, 0, 32'h000, 32'h100, 1, 0, 32'h200); // -> 00
        add(0, 0, 1, 32'h100, 0, 32'h000, 32'h100, 1, 0, 32'h200); // stays 00
        add(0, 0, 1, 32'h100, 1, 32'h204, 32'h100, 1, 0, 32'h200); // -> 01, tgt 204
        add(0, 0, 1, 32'h100, 1, 32'h208, 32'h100, 1, 0, 32'h204); // -> 10, tgt 208
        add(0, 0, 1, 32'h140, 1, 32'h300, 32'h100, 1, 1, 32'h208); // alias replace
        add(0, 0, 0, 32'h000, 0, 32'h000, 32'h100, 0, 0, 32'h000);
        add(0, 0, 1, 32'h140, 1, 32'h300, 32'h140, 1, 1, 32'h300); // -> 11
        add(0, 0, 1, 32'h140, 1, 32'h300, 32'h140, 1, 1, 32'h300); // stays 11
        add(0, 0, 1, 32'h140, 0, 32'h000, 32'h140, 1, 1, 32'h300); // -> 10
        add(0, 0, 1, 32'h140, 0, 32'h000, 32'h140, 1, 1, 32'h300); // -> 01
        add(0, 0, 0, 32'h000, 0, 32'h000, 32'h140, 1, 0, 32'h300);
        add(0, 0, 1, 32'h180, 1, 32'h380, 32'h180, 0, 0, 32'h000); // no bypass
        add(0, 0, 0, 32'h000, 0, 32'h000, 32'h180, 1, 1, 32'h380);
        add(0, 0, 1, 32'h1C0, 0, 32'h000, 32'h1C0, 0, 0, 32'h000); // NT miss
        add(0, 0, 0, 32'h000, 0, 32'h000, 32'h1C0, 0, 0, 32'h000);
        add(0, 0, 0, 32'h180, 1, 32'h999, 32'h180, 1, 1, 32'h380); // uv=0 ignored
        add(0, 0, 0, 32'h000, 0, 32'h000, 32'h180, 1, 1, 32'h380);

        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].uv, vecs[i].upc, vecs[i].ut,
                  vecs[i].utgt, vecs[i].ipc);
            #3;
            check($sformatf("vec%0d", i), vecs[i].eh, vecs[i].et, vecs[i].etgt);
            tick();
        end

        populate_and_kill("flush", 1'b0);
        populate_and_kill("reset", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped entries (power of two, 4..256).
REQ-002 Parameter XLEN, default 32, address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 if_pc  input  XLEN  fetch-stage PC to look up.
REQ-006 predict_hit  output  1  valid entry with matching tag for if_pc.
REQ-007 predict_taken  output  1  predict_hit and entry counter MSB = 1.
REQ-008 predict_target  output  XLEN  stored target of hit entry; 0 when predict_hit = 0.
REQ-009 upd_valid  input  1  EX-stage resolved conditional branch this cycle.
REQ-010 upd_pc  input  XLEN  PC of resolved branch.
REQ-011 upd_taken  input  1  actual branch outcome.
REQ-012 upd_target  input  XLEN  computed branch target.
REQ-013 flush_all  input  1  invalidate all entries (fence.i / context change).

Function
REQ-014 Index = pc[IDXW+1:2], IDXW = log2(ENTRIES); tag = pc[XLEN-1:IDXW+2]; pc[1:0] ignored.
REQ-015 Each entry holds valid, tag, target, 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-016 Lookup is combinational, zero-latency: outputs reflect if_pc and current array contents in the same cycle.
REQ-017 Update applies at the rising edge where upd_valid = 1; no effect when upd_valid = 0.
REQ-018 Update hit (entry valid, tag match): counter increments on taken, decrements on not-taken, saturating at 11 and 00.
REQ-019 Update hit and upd_taken = 1: target overwritten with upd_target.
REQ-020 Update miss and upd_taken = 1: entry allocated/replaced: valid=1, tag, target=upd_target, counter=10.
REQ-021 Update miss and upd_taken = 0: no change to the entry.
REQ-022 Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass).
REQ-023 flush_all = 1 clears every valid bit at the next edge; simultaneous upd_valid is ignored that cycle.
REQ-024 Counter, tag, target of invalid entries are don't-care; outputs gated by valid.

Reset
REQ-025 reset = 1 at a rising edge clears all valid bits and sets all counters to 01; targets/tags need not reset.
REQ-026 reset has priority over flush_all and upd_valid; an update in the reset cycle is discarded.
REQ-027 While reset and after it, predict_hit = 0, predict_taken = 0, predict_target = 0 until a taken update allocates.

Structure
REQ-028 Shared package bp_pkg holds counter state enum (ST_STRONG_NT, ST_WEAK_NT, ST_WEAK_T, ST_STRONG_T) and entry struct typedef.
REQ-029 One sub-module sat_counter2: 2-bit saturating counter next-state function (inputs state, taken; output next state), instantiated for update path.
REQ-030 Valid bits in flops (for single-cycle reset/flush); tag/target/counter arrays may be flop or LUT-RAM.

Verification
REQ-031 After reset, if_pc=0x0000_0100 -> predict_hit=0, predict_taken=0, predict_target=0.
REQ-032 Update pc=0x100 taken target=0x200; next cycle if_pc=0x100 -> hit=1, taken=1 (counter 10), target=0x200.
REQ-033 Two further not-taken updates to 0x100 -> counter 10->01->00; lookup hit=1, taken=0; third not-taken stays 00.
REQ-034 Alias: pc=0x100 allocated, then taken update pc=0x140 (ENTRIES=16, same index) target=0x300 -> lookup 0x100 hit=0; 0x140 hit=1 target=0x300.
REQ-035 Same-cycle lookup 0x180 with first taken update 0x180 -> hit=0 that cycle, hit=1 next cycle.
REQ-036 Populate 4 entries, assert flush_all with upd_valid for new pc=0x1C0 -> all lookups miss next cycle including 0x1C0; repeat with reset instead -> identical result.
